// File: rtl/serial_bit_sender_pkg.sv
// Shared definitions for the serial bit sender and the receiver-side display.
// Holds the state encoding, the default tick divider and the 7-segment digit table.
package serial_bit_sender_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned DEFAULT_DIV_COUNT = 25000000;

  // Active-low {g,f,e,d,c,b,a}; anything above 9 blanks the digit.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = '1;
    endcase
    return seg;
  endfunction

  // A zero or oversized length means "send the whole word".
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int unsigned width);
    logic [3:0] result;
    if (len == 4'd0 || 32'(len) > width) result = 4'(width);
    else result = len;
    return result;
  endfunction

endpackage

// File: rtl/serial_bit_sender_bit_tick_gen.sv
// Bit-period timer: counts unpaused clk cycles and flags the last cycle of each bit.
module bit_tick_gen #(
  parameter int unsigned DIV_COUNT = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CW = (DIV_COUNT < 1) ? 1 : $clog2(DIV_COUNT + 1);

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end = (cnt == CW'(DIV_COUNT));
  assign tick   = at_end && !hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!hold) begin
      if (at_end) cnt <= '0;
      else        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_bit_sender.sv
// Serial transmitter: loads a word, shifts it out MSB-first one bit per tick,
// and shows the number of bits still to send on an active-low 7-segment digit.
module serial_bit_sender
  import serial_bit_sender_pkg::*;
#(
  parameter int unsigned DIV_COUNT = DEFAULT_DIV_COUNT,
  parameter int unsigned WIDTH     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic [WIDTH-1:0] data,
  input  logic [3:0]       len,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [6:0]       seg
);

  state_t             state, state_d;
  logic [WIDTH-1:0]   shreg, shreg_d;
  logic [3:0]         remaining, remaining_d;
  logic               tick;
  logic               timer_clear;

  // Timer only runs in SEND; holding it cleared elsewhere gives cnt=0 on load.
  assign timer_clear = (state != SEND);

  bit_tick_gen #(
    .DIV_COUNT (DIV_COUNT)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .hold  (pause),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      remaining <= '0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      remaining <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    remaining_d = remaining;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_d     = data;
          remaining_d = clamp_len(len, WIDTH);
          state_d     = SEND;
        end
      end
      SEND: begin
        if (tick) begin
          shreg_d     = shreg << 1;
          remaining_d = remaining - 4'd1;
          if (remaining == 4'd1) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bit_out   = (state == SEND) && shreg[WIDTH-1];
    bit_valid = (state == SEND);
    busy      = (state == SEND);
    done      = (state == DONE);
    seg       = digit_to_seg((state == SEND) ? remaining : 4'd0);
  end

endmodule

// File: tb/tb_serial_bit_sender.sv
// Directed bench for serial_bit_sender: timing, pause, clamp, ignored start,
// async reset and a 1100-detector loopback.
module tb_serial_bit_sender;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, pause;
  logic [7:0] data;
  logic [3:0] len;
  logic       bit_out, bit_valid, busy, done;
  logic [6:0] seg;

  logic       start1;
  logic [7:0] data1;
  logic [3:0] len1;
  logic       bit_out1, bit_valid1, busy1, done1;
  logic [6:0] seg1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_bit_sender #(.DIV_COUNT(3), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .data(data), .len(len),
    .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy), .done(done), .seg(seg)
  );

  serial_bit_sender #(.DIV_COUNT(1), .WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .pause(1'b0), .data(data1), .len(len1),
    .bit_out(bit_out1), .bit_valid(bit_valid1), .busy(busy1), .done(done1), .seg(seg1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      default: return 7'b1111111;
    endcase
  endfunction

  // 1100 detector: S0..S4, S4 reached after the full pattern.
  function automatic int det_next(input int s, input logic in_bit);
    case (s)
      0: return in_bit ? 1 : 0;
      1: return in_bit ? 2 : 0;
      2: return in_bit ? 2 : 3;
      3: return in_bit ? 1 : 4;
      default: return in_bit ? 1 : 0;
    endcase
  endfunction

  // Returns at the negedge inside cycle 1 (start sampled at the edge ending cycle 0).
  task automatic launch(input logic [7:0] d, input logic [3:0] l);
    @(negedge clk);
    start = 1'b1; data = d; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic launch1(input logic [7:0] d, input logic [3:0] l);
    @(negedge clk);
    start1 = 1'b1; data1 = d; len1 = l;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic eb, input logic ebusy,
                            input logic edone, input int edig);
    check({tag, " bit_out"},   32'(bit_out),   32'(eb));
    check({tag, " bit_valid"}, 32'(bit_valid), 32'(ebusy));
    check({tag, " busy"},      32'(busy),      32'(ebusy));
    check({tag, " done"},      32'(done),      32'(edone));
    check({tag, " seg"},       32'(seg),       32'(seg_of(edig)));
  endtask

  initial begin
    logic [7:0] pat;
    int         st;
    int         k;
    int         exp_st [4] = '{1, 2, 3, 4};

    reset = 1'b0; start = 1'b0; pause = 1'b0; data = '0; len = '0;
    start1 = 1'b0; data1 = '0; len1 = '0;

    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Basic transfer: 1011_0000, len 4, DIV_COUNT 3.
    launch(8'hB0, 4'd4);
    for (int c = 1; c <= 18; c++) begin
      check_outs($sformatf("basic c%0d", c), (c <= 4) || (c >= 9 && c <= 16),
                 c <= 16, c == 17, (c <= 16) ? 4 - (c - 1) / 4 : 0);
      @(negedge clk);
    end

    // Pause during cycles 6..10 stretches the second bit by 5 cycles.
    launch(8'hB0, 4'd4);
    for (int c = 1; c <= 23; c++) begin
      check_outs($sformatf("pause c%0d", c), (c <= 4) || (c >= 14 && c <= 21),
                 c <= 21, c == 22,
                 (c <= 4) ? 4 : (c <= 13) ? 3 : (c <= 17) ? 2 : (c <= 21) ? 1 : 0);
      if (c == 6)  pause = 1'b1;
      if (c == 11) pause = 1'b0;
      @(negedge clk);
    end

    // Length clamp on the DIV_COUNT=1 instance: len 0 and len 12 both send 8 bits.
    pat = 8'hA5;
    for (int t = 0; t < 2; t++) begin
      launch1(pat, (t == 0) ? 4'd0 : 4'd12);
      for (int c = 1; c <= 18; c++) begin
        check($sformatf("clamp%0d c%0d bit_out", t, c), 32'(bit_out1),
              32'((c <= 16) ? pat[7 - (c - 1) / 2] : 1'b0));
        check($sformatf("clamp%0d c%0d busy", t, c), 32'(busy1), 32'(c <= 16));
        check($sformatf("clamp%0d c%0d done", t, c), 32'(done1), 32'(c == 17));
        @(negedge clk);
      end
    end

    // Start ignored in SEND (c5) and DONE (c17); held into IDLE (c18) it restarts.
    launch(8'hB0, 4'd4);
    for (int c = 1; c <= 24; c++) begin
      if (c <= 17)
        check_outs($sformatf("ign c%0d", c), (c <= 4) || (c >= 9 && c <= 16),
                   c <= 16, c == 17, (c <= 16) ? 4 - (c - 1) / 4 : 0);
      else if (c == 18 || c == 24)
        check_outs($sformatf("ign c%0d", c), 1'b0, 1'b0, 1'b0, 0);
      else if (c <= 22)
        check_outs($sformatf("ign c%0d", c), 1'b1, 1'b1, 1'b0, 1);
      else
        check_outs($sformatf("ign c%0d", c), 1'b0, 1'b0, 1'b1, 0);
      if (c == 5)  begin start = 1'b1; data = 8'hFF; len = 4'd2; end
      if (c == 6)  begin start = 1'b0; data = 8'hB0; len = 4'd4; end
      if (c == 17) begin start = 1'b1; data = 8'h80; len = 4'd1; end
      if (c == 19) start = 1'b0;
      @(negedge clk);
    end

    // Async reset in the middle of cycle 7.
    launch(8'hB0, 4'd4);
    for (int c = 1; c < 7; c++) @(negedge clk);
    check("rst pre busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_outs("rst async", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check_outs("rst held", 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_outs($sformatf("rst after c%0d", c), 1'b0, 1'b0, 1'b0, 0);
    end

    // Loopback into a 1100 detector, sampled once per bit period.
    st = 0;
    k  = 0;
    launch(8'hC0, 4'd4);
    for (int c = 1; c <= 18; c++) begin
      if (c <= 16 && (c - 1) % 4 == 1) begin
        st = det_next(st, bit_out);
        check($sformatf("loop step%0d", k), 32'(st), 32'(exp_st[k]));
        k++;
      end
      if (c == 17) check("loop done", 32'(done), 32'd1);
      @(negedge clk);
    end
    check("loop final", 32'(st), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
